// File: rtl/lcd_pkg.sv
// Shared encodings for the HD44780 read path: FSM states, bus-cycle phases,
// custom-instruction field positions and the result packing helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_SETUP   = 2'd1,
        PH_EN_HIGH = 2'd2,
        PH_HOLD    = 2'd3
    } phase_e;

    typedef struct packed {
        state_e state;
        phase_e phase;
    } dbg_t;

    localparam int BYTE_LSB    = 0;
    localparam int TIMEOUT_BIT = 8;
    localparam int MODE_BIT    = 0;
    localparam int POLL_BIT    = 1;
    localparam int BUSY_BIT    = 7;

    function automatic logic [31:0] pack_result(input logic timeout, input logic [7:0] rd_byte);
        logic [31:0] r;
        r = '0;
        r[BYTE_LSB +: 8] = rd_byte;
        r[TIMEOUT_BIT]   = timeout;
        return r;
    endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Custom-instruction and LCD pin bundle for the read path, plus FSM debug view.
interface lcd_reader_if;
    import lcd_pkg::*;

    // start is a one-cycle request taken only when the block is idle and clk_en=1;
    // done pulses for exactly one enabled cycle with result valid, and result
    // stays stable until the next accepted start. There is no backpressure.
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;
    logic [7:0]  lcd_data_in;
    logic        lcd_enable;
    logic        lcd_rs;
    logic        lcd_rw;
    dbg_t        dbg;

    modport master (
        output clk_en, start, dataa, datab, lcd_data_in,
        input  result, done, lcd_enable, lcd_rs, lcd_rw, dbg
    );

    modport slave (
        input  clk_en, start, dataa, datab, lcd_data_in,
        output result, done, lcd_enable, lcd_rs, lcd_rw, dbg
    );

endinterface

// File: rtl/lcd_bus_cycle.sv
// One timed HD44780 E pulse: setup with E low, E high, then hold with E low.
// Also usable by the write path; the caller owns RS/RW and the data bus.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int EN_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES    = 14
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clk_en,
    input  logic   go,
    output logic   lcd_enable,
    output logic   phase_end,
    output logic   sample,
    output logic   cycle_done,
    output phase_e phase
);

    localparam int M1      = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
    localparam int CNT_MAX = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
        end else if (clk_en) begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        last = 1'b0;
        case (phase_q)
            PH_SETUP:   last = (cnt_q == SETUP_LAST);
            PH_EN_HIGH: last = (cnt_q == EN_LAST);
            PH_HOLD:    last = (cnt_q == HOLD_LAST);
            default:    last = 1'b0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        case (phase_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (go) phase_d = PH_SETUP;
            end
            PH_SETUP:   if (last) begin phase_d = PH_EN_HIGH; cnt_d = '0; end
            PH_EN_HIGH: if (last) begin phase_d = PH_HOLD;    cnt_d = '0; end
            PH_HOLD:    if (last) begin phase_d = PH_IDLE;    cnt_d = '0; end
            default: begin
                phase_d = PH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are qualified by clk_en so a frozen clock never samples or advances.
    always_comb begin
        lcd_enable = (phase_q == PH_EN_HIGH);
        phase_end  = clk_en && last;
        sample     = clk_en && last && (phase_q == PH_EN_HIGH);
        cycle_done = clk_en && last && (phase_q == PH_HOLD);
        phase      = phase_q;
    end

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read custom instruction: status read, data read, and data read
// preceded by busy-flag polling with a bounded poll count.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int EN_HIGH_CYCLES = 12,
    parameter int HOLD_CYCLES    = 14,
    parameter int MAX_POLLS      = 1024
) (
    input  logic       clk,
    input  logic       reset,
    lcd_reader_if.slave bus
);

    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

    state_e        state_q, state_d;
    logic          rs_q, rs_d;
    logic          data_q, data_d;
    logic          poll_q, poll_d;
    logic [PW-1:0] polls_q, polls_d;
    logic [7:0]    byte_q, byte_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   result_q, result_d;

    logic   go, phase_end, sample, cycle_done, bus_en;
    phase_e phase;
    logic   poll_mode, busy, poll_more, poll_timeout, to_data, check_again;
    logic   unused_bits;

    assign unused_bits = ^{bus.datab, bus.dataa[31:2]};

    lcd_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .EN_HIGH_CYCLES(EN_HIGH_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_cycle (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (bus.clk_en),
        .go        (go),
        .lcd_enable(bus_en),
        .phase_end (phase_end),
        .sample    (sample),
        .cycle_done(cycle_done),
        .phase     (phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rs_q      <= 1'b0;
            data_q    <= 1'b0;
            poll_q    <= 1'b0;
            polls_q   <= '0;
            byte_q    <= '0;
            timeout_q <= 1'b0;
            result_q  <= '0;
        end else if (bus.clk_en) begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            poll_q    <= poll_d;
            polls_q   <= polls_d;
            byte_q    <= byte_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
        end
    end

    // Polling only applies to data reads; a status-only read ignores the poll bit.
    always_comb begin
        poll_mode    = data_q && poll_q && !rs_q;
        busy         = byte_q[BUSY_BIT];
        poll_more    = poll_mode && busy && (polls_q < POLL_LIMIT);
        poll_timeout = poll_mode && busy && (polls_q == POLL_LIMIT);
        to_data      = poll_mode && !busy;
        check_again  = poll_more || to_data;
    end

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                    go      = 1'b1;
                end
            end
            ST_SETUP:   if (phase_end)  state_d = ST_EN_HIGH;
            ST_EN_HIGH: if (phase_end)  state_d = ST_HOLD;
            ST_HOLD:    if (cycle_done) state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = check_again ? ST_SETUP : ST_DONE;
                go      = check_again;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rs_d      = rs_q;
        data_d    = data_q;
        poll_d    = poll_q;
        polls_d   = polls_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        byte_d    = sample ? bus.lcd_data_in : byte_q;

        if (state_q == ST_IDLE && bus.start) begin
            data_d    = bus.dataa[MODE_BIT];
            poll_d    = bus.dataa[POLL_BIT];
            rs_d      = bus.dataa[MODE_BIT] && !bus.dataa[POLL_BIT];
            polls_d   = '0;
            timeout_d = 1'b0;
        end

        if (state_q == ST_CHECK) begin
            if (poll_more)    polls_d   = polls_q + PW'(1);
            if (to_data)      rs_d      = 1'b1;
            if (poll_timeout) timeout_d = 1'b1;
            if (!check_again) result_d  = pack_result(timeout_d, byte_q);
        end

        bus.lcd_rw     = (state_q == ST_SETUP) || (state_q == ST_EN_HIGH) ||
                         (state_q == ST_HOLD)  || (state_q == ST_CHECK);
        bus.lcd_rs     = rs_q && bus.lcd_rw;
        bus.lcd_enable = bus_en;
        bus.done       = (state_q == ST_DONE);
        bus.result     = result_q;
        bus.dbg.state  = state_q;
        bus.dbg.phase  = phase;
    end

endmodule

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
- Nios II custom-instruction block that performs HD44780 read cycles (RW=1): the busy-flag/address-counter status read (RS=0) and the data-RAM read (RS=1).
- It is the read-side counterpart of the LCD init/write path and shares the same LCD pins through the top-level mux.
- It optionally polls the busy flag before a data read and returns the byte, plus a timeout flag, in result.

Parameters:
- SETUP_CYCLES, 2, clocks with RS/RW stable and E low before E rises (tAS ≥ 40 ns at 50 MHz).
- EN_HIGH_CYCLES, 12, clocks E is held high (≥ 230 ns). Data is sampled on the last of these clocks.
- HOLD_CYCLES, 14, clocks E is low after the fall, before the next cycle or done (total E cycle ≥ 500 ns).
- MAX_POLLS, 1024, maximum status reads in busy-poll mode before timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  custom-instruction clock enable. The FSM and counters advance only when it is 1.
- start  in  1  one-cycle instruction start, sampled only in IDLE with clk_en=1.
- dataa  in  32  bit0: 0=status read, 1=data read. bit1: busy-poll before the data read. bits 31:2 are ignored.
- datab  in  32  unused, ignored.
- result  out  32  [7:0] byte read, [8] timeout, [31:9]=0. Held until the next start.
- done  out  1  one-cycle completion pulse.
- lcd_data_in  in  8  LCD DB7..DB0 as seen by the FPGA (the top level tristates the pads while lcd_rw=1).
- lcd_enable  out  1  LCD E.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD R/W, 1 for the whole transaction.

Behaviour:
- Reset (synchronous, wins over everything, including a mid-transaction reset):
  - state=IDLE; counters and poll count cleared.
  - lcd_enable=0, lcd_rs=0, lcd_rw=0, done=0, result=0.
- States: IDLE, SETUP, EN_HIGH, HOLD, CHECK, DONE.
- IDLE:
  - lcd_rw=0, lcd_enable=0.
  - Accepting start latches the mode.
  - First cycle: RS=0 if mode is a status read or poll is requested, otherwise RS=1. Go to SETUP.
- SETUP: lcd_rw=1, lcd_rs per the current cycle, E=0 for SETUP_CYCLES clocks, then EN_HIGH.
- EN_HIGH:
  - E=1 for EN_HIGH_CYCLES clocks.
  - On the final clock, lcd_data_in is registered into an internal byte register, then go to HOLD.
- HOLD: E=0, RS/RW unchanged, for HOLD_CYCLES clocks, then CHECK.
- CHECK (1 clock):
  - Status cycle in poll mode, byte[7]=1 and polls<MAX_POLLS: increment the poll count and go to SETUP (RS=0).
  - Status cycle in poll mode, byte[7]=1 and polls==MAX_POLLS: set timeout, skip the data read, go to DONE with result[7:0]=last status.
  - Status cycle in poll mode, byte[7]=0 and data read requested: go to SETUP with RS=1.
  - Otherwise go to DONE.
- DONE (1 clock):
  - done=1; result={23'b0, timeout, byte}; lcd_rw returns to 0.
  - Next state IDLE. A start in the same cycle is ignored.
- clk_en=0 freezes state, counters and all outputs (E stays at its level; the LCD timing minimums are only extended).
- start outside IDLE is ignored.
- Status-only reads (bit0=0) ignore bit1.
- Latency with start accepted at cycle 0:
  - Single read: done at cycle SETUP+EN+HOLD+2 = 30 with defaults, counting the CHECK cycle.
  - Each extra bus cycle adds SETUP+EN+HOLD+1 = 29.
- Poll count width: clog2(MAX_POLLS+1). It resets to 0 on each accepted start.

Decomposition:
- Package lcd_pkg holds:
  - the state encoding;
  - the result field positions (BYTE_LSB=0, TIMEOUT_BIT=8);
  - the dataa bit positions (MODE_BIT=0, POLL_BIT=1);
  - the HD44780 busy-flag bit index (7).
- One sub-module, lcd_bus_cycle, generates one timed E pulse: SETUP/EN_HIGH/HOLD counters, sample strobe and cycle-complete pulse. It is reusable by the write path. lcd_reader owns the sequencing, polling and result.

Test Plan:
1. Status read: dataa=0, lcd_data_in=8'h25 held.
   - Expect rs=0, rw=1, E high exactly 12 clocks starting at cycle 3.
   - Expect done at cycle 30, result=32'h00000025.
2. Data read without poll: dataa=1, lcd_data_in=8'h41.
   - Expect rs=1 throughout, result=32'h00000041.
   - Expect a single E pulse and done pulse width 1.
3. Polled data read: dataa=3, model returns 8'h80 for the first 3 status reads, then 8'h05, then data 8'h5A.
   - Expect 4 RS=0 cycles, 1 RS=1 cycle, result=32'h0000005A.
   - Expect done at cycle 30+4×29=146.
4. Poll timeout: MAX_POLLS=4, dataa=3, status stuck at 8'h80.
   - Expect 5 status cycles, no RS=1 cycle, result=32'h00000180.
5. Reset mid-EN_HIGH: assert reset for 1 clock.
   - Expect next cycle E=0, rw=0, rs=0, result=0, no done.
   - A fresh start then completes normally.
6. clk_en stall: drop clk_en for 7 clocks inside EN_HIGH.
   - Expect E high for 19 clocks total, done delayed by exactly 7, correct byte.
   - A start pulsed during the busy period is ignored.
